// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed common-anode 7-segment driver: latches BCD digits on load,
// scans them with a programmable slot length, optional leading-zero blanking.
module bcd_seg_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [3:0][3:0] dig_q, dig_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            frame_q, frame_d;
  logic            tc, lz, blank;
  logic [3:0]      cur;
  logic [6:0]      dec;

  always_comb begin
    tc      = (presc_q == PW'(REFRESH_DIV - 1));
    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d   = tc ? idx_q + 2'd1 : idx_q;
    frame_d = tc && (idx_q == 2'd3);
    dig_d   = load ? {thousands, hundreds, tens, ones} : dig_q;

    // Output stage looks at the latched digits and current idx, so a load on an
    // advance edge shows up whole in the next slot rather than mid-slot.
    cur = dig_q[idx_q];
    case (idx_q)
      2'd3:    lz = (dig_q[3] == 4'd0);
      2'd2:    lz = (dig_q[3] == 4'd0) && (dig_q[2] == 4'd0);
      2'd1:    lz = (dig_q[3] == 4'd0) && (dig_q[2] == 4'd0) && (dig_q[1] == 4'd0);
      default: lz = 1'b0;
    endcase
    blank = blank_lz && lz;

    case (cur)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase

    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = blank ? 7'b1111111 : dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q   <= '0;
      presc_q <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      frame_q <= 1'b0;
    end else begin
      dig_q   <= dig_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;
endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with REFRESH_DIV=4 (16-cycle frames).
module tb_bcd_seg_scan;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] ones = 4'd0, tens = 4'd0, hundreds = 4'd0, thousands = 4'd0;
  logic       blank_lz = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame;
  int n_run = 0, n_fail = 0;

  localparam logic [6:0] BL = 7'b1111111;

  bcd_seg_scan #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .blank_lz(blank_lz), .an(an), .seg(seg), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame: output after edge j (j=0..15) shows slot j/4; frame pulses after j=15.
  task automatic scan(input string tag, input int j0,
                      input logic [3:0][3:0] ea, input logic [3:0][6:0] es);
    for (int j = j0; j < 16; j++) begin
      @(posedge clk); #1;
      chk({tag, "_an"},  {28'd0, an},  {28'd0, ea[j/4]});
      chk({tag, "_seg"}, {25'd0, seg}, {25'd0, es[j/4]});
      chk({tag, "_frm"}, {31'd0, frame}, {31'd0, (j == 15)});
    end
  endtask

  // Reset, then load digits on the first edge after release (edge j=0 still shows zeros).
  task automatic start(input logic [3:0] th, hu, te, on, input logic blz);
    @(negedge clk);
    rst_n = 1'b0;
    thousands = th; hundreds = hu; tens = te; ones = on;
    blank_lz = blz; load = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  logic [3:0][3:0] an_all, an_lz2, an_lz3;
  logic [3:0][6:0] es;

  initial begin
    an_all = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    an_lz2 = {4'b1111, 4'b1111, 4'b1101, 4'b1110};
    an_lz3 = {4'b1111, 4'b1111, 4'b1111, 4'b1110};

    // reset with arbitrary inputs
    thousands = 4'h7; hundreds = 4'h3; tens = 4'hC; ones = 4'h9; load = 1'b1; blank_lz = 1'b1;
    #12;
    chk("rst_an",  {28'd0, an},  32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_frm", {31'd0, frame}, 32'd0);
    load = 1'b0; blank_lz = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_an",  {28'd0, an},  32'hE);
    chk("rel_seg", {25'd0, seg}, {25'd0, 7'b1000000});

    // 0020, no blanking: two frames
    start(4'd0, 4'd0, 4'd2, 4'd0, 1'b0);
    es = {7'b1000000, 7'b1000000, 7'b0100100, 7'b1000000};
    scan("d0020", 1, an_all, es);
    scan("d0020b", 0, an_all, es);

    // 0020 with blanking
    start(4'd0, 4'd0, 4'd2, 4'd0, 1'b1);
    es = {BL, BL, 7'b0100100, 7'b1000000};
    scan("d0020lz", 1, an_lz2, es);

    // 0000 with blanking: only position 0 lit
    start(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    es = {BL, BL, BL, 7'b1000000};
    scan("d0000lz", 1, an_lz3, es);

    // 1984, then inputs change with load=0
    start(4'd1, 4'd9, 4'd8, 4'd4, 1'b0);
    es = {7'b1111001, 7'b0010000, 7'b0000000, 7'b0011001};
    scan("d1984", 1, an_all, es);
    thousands = 4'd5; hundreds = 4'd5; tens = 4'd5; ones = 4'd5;
    scan("d1984hold", 0, an_all, es);

    // non-BCD tens counts as non-zero, decodes to dash
    start(4'd0, 4'd0, 4'hA, 4'd0, 1'b1);
    es = {BL, BL, 7'b0111111, 7'b1000000};
    scan("dash", 1, an_lz2, es);

    // async reset mid-slot at position 2
    start(4'd1, 4'd9, 4'd8, 4'd4, 1'b0);
    for (int j = 1; j < 10; j++) begin
      @(posedge clk); #1;
    end
    chk("mid_an_pre",  {28'd0, an},  32'hB);
    chk("mid_seg_pre", {25'd0, seg}, {25'd0, 7'b0010000});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an",  {28'd0, an},  32'hF);
    chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
    chk("mid_rst_frm", {31'd0, frame}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_an",  {28'd0, an},  32'hE);
    chk("mid_rel_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    es = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    scan("mid_scan", 1, an_all, es);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Four-digit multiplexed seven-segment display driver that sits directly downstream of the binary-to-BCD converter. It captures the converter's four BCD digits on a load strobe and time-multiplexes them onto a common-anode display. The display is driven with a programmable refresh prescaler, optional leading-zero blanking, and a dash pattern for non-BCD codes. It also emits a one-cycle pulse at the end of each full scan frame.

## Interface
- REFRESH_DIV, 50000, clock cycles each digit slot is held; legal range ≥ 2
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  capture strobe: latch all four digit inputs on this edge
- ones  in  4  BCD digit, display position 0 (rightmost)
- tens  in  4  BCD digit, position 1
- hundreds  in  4  BCD digit, position 2
- thousands  in  4  BCD digit, position 3 (leftmost)
- blank_lz  in  1  1 = suppress leading zeros
- an  out  4  digit enables, active-low, an[i] = position i
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- frame  out  1  one-cycle pulse when the scan wraps from position 3 to 0

## Operation
- Digit latch: 4×4-bit register, cleared by reset. Loaded atomically from the inputs on any edge with load=1. Inputs are ignored while load=0.
- Prescaler: counter 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV). Wraps to 0 at terminal count.
- Scan index idx (2 bits): advances 0→1→2→3→0 on the edge where the prescaler is at terminal count.
- frame=1 for exactly the one cycle following the edge where idx goes 3→0. Otherwise frame=0.
- Decode (seg values listed as g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = dash 0111111
- Leading-zero blanking (blank_lz=1, evaluated on latched digits):
  - position 3 is blanked if thousands==0
  - position 2 is blanked if thousands==0 and hundreds==0
  - position 1 is blanked if the upper three digits are all 0
  - position 0 is never blanked
  - A non-BCD digit counts as non-zero.
- Blanked slot: an=1111, seg=1111111 for the full slot duration.
- Normal slot: an has only bit idx low, and seg shows the decoded latched digit at idx.
- blank_lz is used live (not latched).

## Timing
- Reset (asynchronous, immediate on rst_n low):
  - an=1111, seg=1111111, frame=0
  - idx=0, prescaler=0, latched digits all 0
- Output stage: an/seg are registered from idx, the latched digits and blank_lz. This gives 1-cycle latency.
  - The first edge after reset release gives an=1110, seg=1000000.
  - After idx advances, an/seg reflect the new position on the following edge.
- Each position is displayed for REFRESH_DIV cycles. A full frame is 4×REFRESH_DIV cycles.
- load with a simultaneous idx advance:
  - both take effect on the same edge
  - the output register shows new digit data from the next edge
  - no partial (mixed old/new) frame within a single slot
- Holding load=1 continuously tracks the inputs with 2-cycle input→seg latency.
- Reset asserted mid-slot or mid-frame: all state returns to reset values immediately, and the scan restarts at position 0 with prescaler 0.

## Test plan
- Bench uses REFRESH_DIV=4.
- Reset: drive rst_n=0 with arbitrary inputs -> an=1111, seg=1111111, frame=0. After release and one edge -> an=1110, seg=1000000.
- Load 0020 (thousands=0, hundreds=0, tens=2, ones=0), blank_lz=0 -> each held 4 cycles, then repeats; frame pulses once every 16 cycles:
  - an=1110 seg=1000000
  - an=1101 seg=0100100
  - an=1011 seg=1000000
  - an=0111 seg=1000000
- Same 0020 with blank_lz=1 -> positions 0,1 as above; positions 2,3 give an=1111, seg=1111111. Load 0000 with blank_lz=1 -> only position 0 is lit, seg=1000000.
- Load 1984 -> positions 0..3 show:
  - 0011001
  - 0000000
  - 0010000
  - 1111001
  Then change the inputs with load=0 -> display unchanged.
- Load tens=4'hA, others 0, blank_lz=1 -> position 1 shows dash 0111111. Position 0 shows 1000000. Positions 2,3 are blanked.
- Pulse rst_n low mid-slot at position 2, between clock edges -> an/seg go to reset values with no clock edge. After release the scan restarts at an=1110 with seg=1000000, because the latch is cleared.
